// File: rtl/fetch_queue.sv
// Instruction-fetch stage: drives a 1-cycle-latency ROM and buffers PC-tagged instructions in a FIFO.
// Optional same-cycle head bypass of returning ROM data is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 16,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_data,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [DATA_W-1:0]          id_instr,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [DATA_W-1:0] r_instr_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc_mem    [DEPTH];

    logic              w_empty;
    logic              w_issue;
    logic              w_ret;
    logic              w_bypass;
    logic              w_valid;
    logic              w_pop;
    logic              w_pop_fifo;
    logic              w_push;
    logic [DATA_W-1:0] w_head_instr;
    logic [ADDR_W-1:0] w_head_pc;

    // Handshake: a transfer happens on every rising edge where id_valid && id_ready;
    // id_valid never depends on id_ready, and id_instr/id_pc are stable while id_valid is high
    // and no transfer or redirect occurs. A transfer in a redirect cycle still counts.
    assign w_empty = (r_count == '0);
    // Issue credit counts the in-flight read; a pop this cycle does not free a slot until next cycle.
    assign w_issue = !redirect && ((r_count + CW'(r_inflight)) < DEPTH_C);
    assign w_ret   = r_inflight && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && w_ret;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_valid    = !w_empty || w_bypass;
    assign w_pop      = w_valid && id_ready;
    assign w_pop_fifo = w_pop && !w_empty;
    // A bypassed return that decode takes directly never occupies a slot.
    assign w_push     = w_ret && !(w_bypass && id_ready);

    assign w_head_instr = w_bypass ? imem_data     : r_instr_mem[r_rd_ptr];
    assign w_head_pc    = w_bypass ? r_inflight_pc : r_pc_mem[r_rd_ptr];

    assign imem_addr = r_pc;
    assign id_valid  = w_valid;
    assign id_instr  = w_valid ? w_head_instr : '0;
    assign id_pc     = w_valid ? w_head_pc    : '0;
    assign count     = r_count;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_issue) begin
                r_pc          <= r_pc + ADDR_W'(1);
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_pc;
            end else begin
                r_inflight    <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_fifo) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop_fifo})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible when counted as occupied.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imem_data;
            r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, stall/fill, redirect, redirect with handshake,
// asynchronous reset pulse and PC wrap (second instance with RESET_PC = 0xFFFE).
module tb_fetch_queue;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        CLK;
    logic        rst, rst2;
    logic        redirect, redirect2;
    logic [15:0] redirect_pc, redirect_pc2;
    logic [15:0] imem_addr, imem_addr2;
    logic [15:0] imem_data, imem_data2;
    logic        id_valid, id_valid2;
    logic        id_ready, id_ready2;
    logic [15:0] id_instr, id_instr2;
    logic [15:0] id_pc, id_pc2;
    logic [2:0]  count, count2;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] exp_q[$];
    logic [15:0] acc_q[$];

    fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .CLK(CLK), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data), .id_valid(id_valid),
        .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .count(count)
    );

    fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'hFFFE)) dut_wrap (
        .CLK(CLK), .rst(rst2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .imem_addr(imem_addr2), .imem_data(imem_data2), .id_valid(id_valid2),
        .id_ready(id_ready2), .id_instr(id_instr2), .id_pc(id_pc2), .count(count2)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // synchronous ROM models: ROM[a] = 0x1000 + a
    always @(posedge CLK) begin
        imem_data  <= 16'h1000 + imem_addr;
        imem_data2 <= 16'h1000 + imem_addr2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: record handshake of the current cycle, then advance one edge
    task automatic tick();
        #1;
        if (id_valid && id_ready) acc_q.push_back(id_pc);
        @(posedge CLK);
        #1;
    endtask

    task automatic sb_check(input string tag);
        check({tag, "_len"}, 32'(acc_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < acc_q.size()) check(tag, 32'(acc_q[i]), 32'(exp_q[i]));
        end
        acc_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0; rst2 = 1'b0;
        redirect = 1'b0; redirect2 = 1'b0;
        redirect_pc = '0; redirect_pc2 = '0;
        id_ready = 1'b0; id_ready2 = 1'b1;
        @(posedge CLK); #1;
        tick();

        // reset state
        check("rst_valid", 32'(id_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_instr", 32'(id_instr), 0);
        check("rst_pc", 32'(id_pc), 0);
        check("rst_addr_wrap", 32'(imem_addr2), 32'h0000FFFE);

        // release mid-cycle, stream with decode ready
        rst = 1'b1;
        id_ready = 1'b1;
        repeat (LAT - 2) tick();
        check("first_valid_early", 32'(id_valid), 0);
        tick();
        check("first_valid", 32'(id_valid), 1);
        check("first_pc", 32'(id_pc), 0);
        check("first_instr", 32'(id_instr), 32'h1000);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("stream_valid", 32'(id_valid), 1);
            check("stream_pc", 32'(id_pc), 32'(i));
            check("stream_instr", 32'(id_instr), 32'h1000 + 32'(i));
        end

        // stall with pc 5 at head: fill to DEPTH, fetch pc freezes at 9
        id_ready = 1'b0;
        repeat (10) tick();
        check("stall_count", 32'(count), 4);
        check("stall_addr", 32'(imem_addr), 9);
        check("stall_pc", 32'(id_pc), 5);
        id_ready = 1'b1;
        for (int i = 5; i <= 10; i++) begin
            check("drain_valid", 32'(id_valid), 1);
            check("drain_pc", 32'(id_pc), 32'(i));
            if (i < 10) tick();
        end
        for (int i = 0; i <= 9; i++) exp_q.push_back(16'(i));
        sb_check("sb_stream");

        // build count = 3 with one read in flight
        id_ready = 1'b0;
        repeat (10) tick();
        check("fill_count", 32'(count), 4);
        check("fill_addr", 32'(imem_addr), 14);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        tick();
        check("pre_redir_count", 32'(count), 3);
        check("pre_redir_pc", 32'(id_pc), 11);
        check("pre_redir_addr", 32'(imem_addr), 15);
        exp_q.push_back(16'd10);
        sb_check("sb_fill");

        // redirect to 0x0040 with no handshake
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check("redir_count", 32'(count), 0);
        check("redir_valid", 32'(id_valid), 0);
        check("redir_pc_out", 32'(id_pc), 0);
        check("redir_instr_out", 32'(id_instr), 0);
        check("redir_addr", 32'(imem_addr), 32'h40);
        id_ready = 1'b1;
        repeat (LAT - 2) tick();
        check("redir_valid_early", 32'(id_valid), 0);
        tick();
        check("redir_first_valid", 32'(id_valid), 1);
        check("redir_first_pc", 32'(id_pc), 32'h40);
        check("redir_first_instr", 32'(id_instr), 32'h1040);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("redir_stream_pc", 32'(id_pc), 32'h40 + 32'(i));
        end
        id_ready = 1'b0;
        tick();
        check("hold_pc", 32'(id_pc), 32'h43);
        id_ready = 1'b1;
        for (int i = 4; i <= 7; i++) begin
            tick();
            check("pre_hs_pc", 32'(id_pc), 32'h40 + 32'(i));
        end

        // redirect coinciding with handshake on pc 0x47
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check("hs_redir_valid", 32'(id_valid), 0);
        repeat (LAT - 1) tick();
        check("hs_next_valid", 32'(id_valid), 1);
        check("hs_next_pc", 32'(id_pc), 32'h100);
        for (int i = 0; i <= 7; i++) exp_q.push_back(16'h0040 + 16'(i));
        sb_check("sb_redirect");
        tick();
        check("post_hs_pc", 32'(id_pc), 32'h101);

        // asynchronous reset pulse between edges
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(id_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_pc", 32'(id_pc), 0);
        check("arst_instr", 32'(id_instr), 0);
        check("arst_addr", 32'(imem_addr), 0);
        @(posedge CLK); #1;
        rst = 1'b1;
        repeat (LAT - 2) tick();
        check("restart_valid_early", 32'(id_valid), 0);
        tick();
        check("restart_valid", 32'(id_valid), 1);
        check("restart_pc", 32'(id_pc), 0);
        check("restart_instr", 32'(id_instr), 32'h1000);
        tick();
        check("restart_pc1", 32'(id_pc), 1);

        // PC wrap from RESET_PC = 0xFFFE
        rst2 = 1'b1;
        repeat (LAT - 1) tick();
        check("wrap_valid", 32'(id_valid2), 1);
        check("wrap_pc0", 32'(id_pc2), 32'hFFFE);
        check("wrap_instr0", 32'(id_instr2), 32'h0FFE);
        tick();
        check("wrap_pc1", 32'(id_pc2), 32'hFFFF);
        tick();
        check("wrap_pc2", 32'(id_pc2), 32'h0000);
        check("wrap_instr2", 32'(id_instr2), 32'h1000);
        tick();
        check("wrap_pc3", 32'(id_pc2), 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch stage that replaces the bare PC register plus flushable IF/ID register.
- Drives a synchronous instruction ROM with 1-cycle read latency and buffers returned instructions, each tagged with its PC, in a DEPTH-entry FIFO.
- Hands instructions to decode over a valid/ready handshake.
- Branch redirect flushes the queue and kills the in-flight read, so decode stalls no longer lose fetched instructions.

Parameters:
- DATA_W, 16, instruction width in bits
- ADDR_W, 16, PC / ROM address width in bits
- DEPTH, 4, FIFO entries; power of two, >= 2
- RESET_PC, 0, first fetch address after reset

Ports:
- CLK  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset (asserted when 0)
- redirect  input  1  branch taken; flush and refetch
- redirect_pc  input  ADDR_W  redirect target
- imem_addr  output  ADDR_W  ROM read address (= pc_q)
- imem_data  input  DATA_W  ROM output; valid 1 cycle after its address is issued
- id_valid  output  1  head entry valid
- id_ready  input  1  decode accepts head
- id_instr  output  DATA_W  head instruction; 0 when empty
- id_pc  output  ADDR_W  PC of head instruction; 0 when empty
- count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - pc_q = RESET_PC
  - count = 0, rd/wr pointers = 0
  - inflight_q = 0, inflight_pc_q = 0
  - all outputs 0 except imem_addr = RESET_PC
- Reset released mid-stream resumes fetch from RESET_PC; any prior ROM data is ignored.
- Issue:
  - issue = !redirect && (count + inflight_q < DEPTH).
  - A pop in the same cycle does not create issue credit.
  - On issue: pc_q <= pc_q + 1 (mod 2^ADDR_W, so 0xFFFF wraps to 0x0000), inflight_q <= 1, inflight_pc_q <= pc_q.
  - No issue: inflight_q <= 0 and pc_q holds.
- Return: when inflight_q == 1 and redirect == 0, imem_data and inflight_pc_q are written at the tail at the end of that cycle.
- Pop: id_valid && id_ready advances the head at the clock edge.
  - Push and pop in the same cycle leave count unchanged.
  - Push into a full queue cannot occur, because issue is gated.
- Head outputs are combinational from the FIFO head. id_valid = (count != 0).
- Redirect has priority over issue, return and pop. At the edge of a redirect cycle:
  - count <= 0, pointers <= 0
  - inflight_q <= 0 (returning data is discarded)
  - pc_q <= redirect_pc
- A handshake in the redirect cycle is a valid transfer: decode keeps that instruction. Everything else is dropped.
- Redirect on consecutive cycles: only the last target is fetched.
- Latency without bypass:
  - redirect in cycle r → imem_addr = target in r+1 → data returns in r+2 → id_valid = 1 in r+3.
  - Steady state delivers 1 instruction/cycle while id_ready = 1.
- Stalled decode (id_ready = 0): fetch continues until count + inflight = DEPTH, then pc_q holds. No instruction is lost or duplicated.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when count == 0 and a valid return occurs, the head outputs show imem_data / inflight_pc_q with id_valid = 1 in the same cycle.
  - If id_ready is high, the entry is consumed and not written.
  - Otherwise it is written as normal.
  - Redirect-to-id_valid latency drops to 2 cycles (r+2).
- Undefined: no bypass path; latency 3 cycles, as above.

Test Plan:
- Reset release, ROM[i] = 0x1000+i, id_ready = 1 → id_valid first high cycle 3 after release with id_pc = 0, id_instr = 0x1000; then pc 1, 2, 3… on consecutive cycles, no gaps.
- Hold id_ready = 0 for 10 cycles → count settles at 4, imem_addr frozen at 4. Release → id_pc sequence 0, 1, 2, 3, 4, 5 with no skip or repeat.
- redirect = 1, redirect_pc = 0x0040 while count = 3 and inflight = 1 → next cycle count = 0, id_valid = 0. id_pc = 0x0040 appears in r+3 (r+2 with FETCH_QUEUE_BYPASS_EN). Stale PCs never appear.
- redirect coinciding with a handshake on id_pc = 7 → pc 7 counted as transferred. Next valid id_pc is redirect_pc.
- RESET_PC = 0xFFFE → fetched id_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst pulsed low asynchronously mid-stream (between edges) → outputs 0 and count 0 immediately. After release, fetch restarts at RESET_PC.
